// File: rtl/cdm_sweep_ctrl.sv
// Exhaustive 8x8 sweep controller for characterising an external approximate multiplier.
// Drives every (a,b) operand pair, samples the returned product, and accumulates error statistics.
module cdm_sweep_ctrl #(
    parameter int WAIT_CYC = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic [7:0]  mul_a,
    output logic [7:0]  mul_b,
    input  logic [15:0] mul_r,
    output logic        busy,
    output logic        done,
    output logic [16:0] err_count,
    output logic [31:0] sum_abs_err,
    output logic [15:0] max_abs_err
);

    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

    localparam logic [3:0] HOLD_LAST = 4'(WAIT_CYC - 1);

    state_t      state_q, state_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [3:0]  hold_q, hold_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [16:0] err_q, err_d;
    logic [31:0] sum_q, sum_d;
    logic [15:0] max_q, max_d;

    logic [15:0] exact;
    logic [15:0] abs_err;

    assign exact   = 16'(a_q) * 16'(b_q);
    assign abs_err = (exact >= mul_r) ? (exact - mul_r) : (mul_r - exact);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        hold_d  = hold_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = err_q;
        sum_d   = sum_q;
        max_d   = max_q;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = DRIVE;
                    busy_d  = 1'b1;
                    a_d     = 8'd0;
                    b_d     = 8'd0;
                    hold_d  = 4'd0;
                    err_d   = 17'd0;
                    sum_d   = 32'd0;
                    max_d   = 16'd0;
                end
            end
            DRIVE: begin
                busy_d = 1'b1;
                if (abort) begin
                    // Partial statistics are kept; only the operand walk is discarded.
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    a_d     = 8'd0;
                    b_d     = 8'd0;
                    hold_d  = 4'd0;
                end else if (hold_q == HOLD_LAST) begin
                    err_d  = err_q + {16'd0, |abs_err};
                    sum_d  = sum_q + {16'd0, abs_err};
                    max_d  = (abs_err > max_q) ? abs_err : max_q;
                    hold_d = 4'd0;
                    b_d    = b_q + 8'd1;
                    if (b_q == 8'hFF) begin
                        a_d = a_q + 8'd1;
                        if (a_q == 8'hFF) begin
                            // Both operands wrap to zero on their own here.
                            state_d = DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= 8'd0;
            b_q     <= 8'd0;
            hold_q  <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 17'd0;
            sum_q   <= 32'd0;
            max_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            sum_q   <= sum_d;
            max_q   <= max_d;
        end
    end

    assign mul_a       = a_q;
    assign mul_b       = b_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_count   = err_q;
    assign sum_abs_err = sum_q;
    assign max_abs_err = max_q;

endmodule
